// File: rtl/gfx_primitive_assembly_pkg.sv
// Shared helpers for primitive assembly: assembly mode encoding, counter sizing, winding order.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gfx_primitive_assembly_pkg;

    // Assembly mode latched on the first word of each vertex.
    typedef enum logic {
        MODE_LIST  = 1'b0,
        MODE_STRIP = 1'b1
    } asm_mode_e;

    // Width of a counter that ranges 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Maps output vertex position to an assembly slot. Odd strip triangles
    // swap the first two vertices so every triangle keeps the same winding.
    function automatic logic [1:0] emit_slot(input logic odd, input logic [1:0] pos);
        logic [1:0] sel;
        case (pos)
            2'd0:    sel = odd ? 2'd1 : 2'd0;
            2'd1:    sel = odd ? 2'd0 : 2'd1;
            default: sel = 2'd2;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gfx_defs.sv
// Shared vertex/triangle definitions for the primitive assembly slice.
// GFX_VERTEX_WORDS / GFX_WORD_BITS give parameter defaults; GFX_DECLARE_TYPES
// declares gfx_vertex (words x bits, word 0 lowest) and gfx_triangle (3 vertices,
// v0 lowest) inside a module body using that module's own parameters.
`ifndef GFX_DEFS_SV
`define GFX_DEFS_SV

`define GFX_VERTEX_WORDS 4
`define GFX_WORD_BITS 32

`define GFX_DECLARE_TYPES(vw, wb) \
    typedef logic [(vw)-1:0][(wb)-1:0] gfx_vertex; \
    typedef gfx_vertex [2:0] gfx_triangle;

`endif

// File: rtl/gfx_vertex_gather.sv
// Gathers component words into one vertex; resyncs on malformed starts, flags desync.
// Latency: vtx_vld/vtx_dat are combinational in the cycle the last word is accepted.
// Backpressure: none of its own; word_vld must already be the accepted handshake.
//
// Ports: clk/rst_n; word_vld/word_start/word_dat accepted input word;
//        vtx_vld/vtx_dat completed vertex pulse; desync sticky resync flag.
`include "gfx_defs.sv"

module gfx_vertex_gather
    import gfx_primitive_assembly_pkg::*;
#(
    parameter int VERTEX_WORDS = `GFX_VERTEX_WORDS,
    parameter int WORD_BITS    = `GFX_WORD_BITS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            word_vld,
    input  logic                            word_start,
    input  logic [WORD_BITS-1:0]            word_dat,
    output logic                            vtx_vld,
    output logic [VERTEX_WORDS*WORD_BITS-1:0] vtx_dat,
    output logic                            desync
);

    `GFX_DECLARE_TYPES(VERTEX_WORDS, WORD_BITS)

    localparam int WCW = cnt_bits(VERTEX_WORDS);
    localparam logic [WCW-1:0] LAST = WCW'(VERTEX_WORDS - 1);

    logic [WCW-1:0] wc;
    logic [WCW-1:0] pos;
    logic           take;
    logic           orphan;
    logic           restart;
    gfx_vertex      sreg;
    gfx_vertex      shift_nxt;

    always_comb begin
        // A start word always lands in component 0, even mid-vertex.
        pos     = word_start ? '0 : wc;
        take    = word_vld && (word_start || (wc != '0));
        orphan  = word_vld && !word_start && (wc == '0);
        restart = word_vld && word_start && (wc != '0);
        vtx_vld = take && (pos == LAST);

        // Words enter at the top and walk down, so after a full vertex
        // component 0 sits in the lowest position. Stale words of a dropped
        // partial vertex are pushed out by the time the restart completes.
        shift_nxt = sreg;
        shift_nxt[VERTEX_WORDS-1] = word_dat;
        for (int i = 0; i < VERTEX_WORDS - 1; i++) begin
            shift_nxt[i] = sreg[i+1];
        end
    end

    assign vtx_dat = shift_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc     <= '0;
            sreg   <= '0;
            desync <= 1'b0;
        end else begin
            if (take) begin
                sreg <= shift_nxt;
                wc   <= vtx_vld ? '0 : pos + WCW'(1);
            end
            if (orphan || restart) begin
                desync <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfx_primitive_assembly.sv
// Assembles per-component vertex words into triangles (list, optionally strip).
// Latency: out_valid rises the cycle after the last word of the completing vertex.
// Backpressure: in_ready = !out_valid || out_ready; output held stable while stalled.
//
// Ports: clk/rst_n; in_valid/in_ready/in_start/in_data word stream;
//        strip (only with GFX_ASSEMBLY_STRIP_EN) mode select sampled on start words;
//        out_valid/out_ready/out_data triangle (v0 in LSBs); desync sticky flag.
// Build option: define GFX_ASSEMBLY_STRIP_EN to add triangle-strip assembly.
`include "gfx_defs.sv"

module gfx_primitive_assembly
    import gfx_primitive_assembly_pkg::*;
#(
    parameter int VERTEX_WORDS = `GFX_VERTEX_WORDS,
    parameter int WORD_BITS    = `GFX_WORD_BITS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_start,
    input  logic [WORD_BITS-1:0]                in_data,
`ifdef GFX_ASSEMBLY_STRIP_EN
    input  logic                                strip,
`endif
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [3*VERTEX_WORDS*WORD_BITS-1:0] out_data,
    output logic                                desync
);

    `GFX_DECLARE_TYPES(VERTEX_WORDS, WORD_BITS)

    logic            acc;
    logic            vtx_vld;
    gfx_vertex       vtx;
    // Two held vertices; the third of a triangle is the one completing now.
    gfx_vertex [1:0] slots;
    logic [1:0]      vc;
    logic [1:0]      vc_eff;
    logic            odd_eff;
    logic            strip_eff;
    logic            load;
    gfx_triangle     tri_in;
    gfx_triangle     tri_out;

    // Conservative: a stalled triangle blocks input even if a slot is free.
    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    gfx_vertex_gather #(
        .VERTEX_WORDS (VERTEX_WORDS),
        .WORD_BITS    (WORD_BITS)
    ) u_gather (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_vld   (acc),
        .word_start (in_start),
        .word_dat   (in_data),
        .vtx_vld    (vtx_vld),
        .vtx_dat    (vtx),
        .desync     (desync)
    );

`ifdef GFX_ASSEMBLY_STRIP_EN
    asm_mode_e mode;
    logic      parity;
    logic      mode_chg;

    // A mode switch restarts assembly so no triangle mixes list and strip vertices.
    always_comb begin
        mode_chg  = acc && in_start && (asm_mode_e'(strip) != mode);
        vc_eff    = mode_chg ? 2'd0 : vc;
        odd_eff   = mode_chg ? 1'b0 : parity;
        strip_eff = mode_chg ? strip : (mode == MODE_STRIP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_LIST;
            parity <= 1'b0;
        end else begin
            if (mode_chg) begin
                mode <= asm_mode_e'(strip);
            end
            if (load && strip_eff) begin
                parity <= !odd_eff;
            end else if (mode_chg) begin
                parity <= 1'b0;
            end
        end
    end
`else
    assign vc_eff    = vc;
    assign odd_eff   = 1'b0;
    assign strip_eff = 1'b0;
`endif

    always_comb begin
        tri_in[0] = slots[0];
        tri_in[1] = slots[1];
        tri_in[2] = vtx;
        load      = vtx_vld && (vc_eff == 2'd2);
        tri_out   = tri_in;
        for (int k = 0; k < 3; k++) begin
            tri_out[k] = tri_in[emit_slot(odd_eff, 2'(k))];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
            vc    <= 2'd0;
        end else if (vtx_vld) begin
            if (vc_eff == 2'd2) begin
                if (strip_eff) begin
                    // Slide the window: oldest vertex drops out, vc stays full.
                    slots[0] <= slots[1];
                    slots[1] <= vtx;
                    vc       <= 2'd2;
                end else begin
                    vc <= 2'd0;
                end
            end else begin
                slots[vc_eff[0]] <= vtx;
                vc               <= vc_eff + 2'd1;
            end
        end else begin
            vc <= vc_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= tri_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/gfx_primitive_assembly.md
# gfx_primitive_assembly

Consumes the per-component vertex stream leaving the perspective-division stage (one word per cycle, first component flagged by `in_start`). It gathers complete vertices and emits one assembled triangle, three vertices wide, per output handshake toward the rasterizer setup stage. The block supports triangle lists and, optionally, triangle strips. It also resynchronises on a malformed vertex.

## Interface
Parameters:
- `VERTEX_WORDS`, default 4: components per vertex (x, y, z, w); must be at least 1.
- `WORD_BITS`, default 32: width of one component (fp32).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when high together with `in_valid`.
- `in_start`  in  1  the word is component 0 of a vertex.
- `in_data`  in  `WORD_BITS`  component word.
- `strip`  in  1  strip mode select; present only with `GFX_ASSEMBLY_STRIP_EN`.
- `out_valid`  out  1  triangle valid.
- `out_ready`  in  1  downstream accepts the triangle.
- `out_data`  out  `3*VERTEX_WORDS*WORD_BITS`  vertices v0, v1, v2, with v0 in the LSBs and component 0 lowest within each vertex.
- `desync`  out  1  sticky flag: a partial vertex was dropped.

## Operation
Counters and buffering:
- Word counter `wc` ranges 0..`VERTEX_WORDS-1`.
- Vertex counter `vc` ranges 0..2.
- An assembly buffer holds up to 3 vertices.
- A separate output register holds the triangle being offered.

Accepted word with `in_start`=1:
- If `wc`≠0, the partial vertex is discarded and `desync` is set.
- The word is stored as component 0 of slot `vc`, and `wc` becomes 1.

Accepted word with `in_start`=0:
- If `wc`=0, the word is dropped and `desync` is set (it is an orphan component).
- Otherwise the word is stored at component `wc`, and `wc` increments.

Vertex completion (the word at `wc`=`VERTEX_WORDS-1` is accepted):
- `wc` returns to 0.
- List mode: if `vc`=2, the triangle is copied to the output register, `out_valid` is set, and `vc` returns to 0. Otherwise `vc` increments.

Flow control:
- `in_ready` = !`out_valid` || `out_ready`. This is conservative: input stalls whenever a triangle is pending and not being taken.
- `out_valid` clears on `out_ready` unless a new triangle is loaded in the same cycle, in which case it stays high with the new data.
- `out_data` is stable while `out_valid` && !`out_ready`.
- `desync` clears only on reset.

## Timing
- Reset values: `out_valid`=0, `desync`=0, `wc`=0, `vc`=0, `out_data`=0, `in_ready`=1.
- Latency: `out_valid` rises in the cycle after the last word of the third vertex is accepted.
- Throughput: one word per cycle. With `VERTEX_WORDS`=4 in list mode, this is one triangle per 12 cycles while `out_ready` is held high.
- Back-to-back: the last word of triangle N+1 may be accepted in the same cycle that triangle N is taken.
- Reset mid-operation: the partial vertex or triangle and any pending output are lost with no output.

## Configuration
- `GFX_ASSEMBLY_STRIP_EN` defined:
  - The `strip` port exists. It is sampled on each accepted `in_start` word.
  - A change of mode relative to the latched mode forces `vc`=0 and clears the strip parity bit before the word is stored.
  - In strip mode, after the first triangle every completed vertex emits a triangle from the last three vertices. The slots shift so the oldest vertex is discarded.
  - Winding alternates: even parity emits (v0, v1, v2) and odd parity emits (v1, v0, v2). Parity toggles per emitted triangle.
- `GFX_ASSEMBLY_STRIP_EN` undefined: there is no `strip` port and list mode only.

## Structure
- Shared items go in the `gfx_defs.sv` include: `GFX_VERTEX_WORDS`, and packed typedefs `gfx_vertex` (`VERTEX_WORDS` × `WORD_BITS`) and `gfx_triangle` (3 × `gfx_vertex`).
- Sub-module `gfx_vertex_gather`: the word counter, the resync/`desync` logic and a one-vertex shift register. It emits a completed vertex pulse. The top level holds the vertex slots, the strip logic and the output register.

## Test plan
- List mode, `VERTEX_WORDS`=4, words 1..12 streamed with `in_start` on words 1, 5 and 9, `out_ready`=1 → `out_valid` for exactly 1 cycle, the cycle after word 12; `out_data` words 0..11 = 1..12.
- `out_ready`=0 with 24 words offered → first triangle held stable; `in_ready` low from the cycle after word 12. Raising `out_ready` → words 13..24 resume and produce the second triangle.
- `in_start` on word 3 of a vertex → `desync`=1; the two partial words are discarded; the triangle assembles from the restarted vertex.
- Orphan word (`in_start`=0) right after reset → dropped and `desync`=1; `vc` and `wc` remain 0.
- Strip build, `strip`=1, 5 vertices A–E → triangles (A,B,C), (C,B,D), (C,D,E).
- Strip build, toggling `strip` to 0 after 4 vertices → the next 3 vertices form one list triangle, with no mixed-mode output.
